// File: rtl/breadboard_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : breadboard_driver
//  Description : Sequential command issuer for the 4-bit BreadBoard ALU.
//                Takes one request on a valid/ready handshake, drives the ALU
//                pins for SETTLE cycles, captures result/error and returns
//                them on a second valid/ready handshake.
//                Optional feature macro: BREADBOARD_DRIVER_CHAIN_EN adds the
//                req_chain input (operand A taken from the last result).
//  Revision    : 1.0 - initial release
// ============================================================================
module breadboard_driver #(
    parameter int SETTLE = 2            // cycles alu_* is held before capture (1..15)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic [3:0] req_cmd,
`ifdef BREADBOARD_DRIVER_CHAIN_EN
    input  logic       req_chain,
`endif
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_cmd,
    input  logic [3:0] alu_result,
    input  logic       alu_error,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_error,
    output logic [3:0] rsp_cmd
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] settle_cnt;
    logic [3:0] operand_a;

    // Operand A source: the previous captured result when chaining, else req_a.
`ifdef BREADBOARD_DRIVER_CHAIN_EN
    assign operand_a = req_chain ? rsp_result : req_a;
`else
    assign operand_a = req_a;
`endif

    // Request/settle/capture/respond sequencer with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            req_ready  <= 1'b0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_cmd    <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_result <= 4'd0;
            rsp_error  <= 1'b0;
            rsp_cmd    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is raised one cycle after reset and stays up
                    // until a request is taken.
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        alu_a      <= operand_a;
                        alu_b      <= req_b;
                        alu_cmd    <= req_cmd;
                        settle_cnt <= SETTLE_LOAD;
                        req_ready  <= 1'b0;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    // Only ADD/SUB trust the ALU; other codes are resolved here.
                    if (alu_cmd == CMD_ADD || alu_cmd == CMD_SUB) begin
                        rsp_result <= alu_result;
                        rsp_error  <= alu_error;
                    end else if (alu_cmd == CMD_NOP) begin
                        rsp_result <= 4'd0;
                        rsp_error  <= 1'b0;
                    end else begin
                        rsp_result <= 4'd0;
                        rsp_error  <= 1'b1;
                    end
                    rsp_cmd   <= alu_cmd;
                    rsp_valid <= 1'b1;
                    state     <= RESPOND;
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_breadboard_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_breadboard_driver
//  Description : Self-checking bench for breadboard_driver with a BreadBoard
//                ALU stand-in and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_breadboard_driver;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [3:0] req_cmd;
    logic       req_chain;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_cmd;
    logic [3:0] alu_result;
    logic       alu_error;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_error;
    logic [3:0] rsp_cmd;

    logic [3:0] junk;
    logic [3:0] bb_sum;
    logic [3:0] bb_diff;

    int checks   = 0;
    int failures = 0;
    int last_res = 0;

    always #5 clk = ~clk;

    breadboard_driver #(.SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cmd    (req_cmd),
`ifdef BREADBOARD_DRIVER_CHAIN_EN
        .req_chain  (req_chain),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cmd    (alu_cmd),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .rsp_cmd    (rsp_cmd)
    );

    // BreadBoard stand-in: ADD/SUB with signed overflow, garbage otherwise.
    assign bb_sum  = alu_a + alu_b;
    assign bb_diff = alu_a - alu_b;
    always_comb begin
        alu_result = junk;
        alu_error  = junk[0];
        if (alu_cmd == 4'd1) begin
            alu_result = bb_sum;
            alu_error  = (alu_a[3] == alu_b[3]) && (bb_sum[3] != alu_a[3]);
        end else if (alu_cmd == 4'd2) begin
            alu_result = bb_diff;
            alu_error  = (alu_a[3] != alu_b[3]) && (bb_diff[3] != alu_a[3]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: signed 4-bit arithmetic done on plain integers.
    function automatic void model(input int a, input int b, input int cmd,
                                  output int res, output int err);
        int sa, sb, v;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        if (cmd == 1 || cmd == 2) begin
            v   = (cmd == 1) ? sa + sb : sa - sb;
            res = v & 15;
            err = (v > 7 || v < -8) ? 1 : 0;
        end else begin
            res = 0;
            err = (cmd == 0) ? 0 : 1;
        end
    endfunction

    // One full transaction; hold = extra cycles with rsp_ready low,
    // poke = drive competing requests and stray rsp_ready while busy.
    task automatic do_op(input int a, input int b, input int cmd, input bit chain,
                         input int hold, input bit poke);
        int ea, er, ee, lat;
        ea = a;
`ifdef BREADBOARD_DRIVER_CHAIN_EN
        if (chain) ea = last_res;
`endif
        model(ea, b, cmd, er, ee);
        junk = 4'($urandom);
        @(negedge clk);
        req_a = 4'(a); req_b = 4'(b); req_cmd = 4'(cmd); req_chain = chain; req_valid = 1'b1;
        lat = 0;
        while (!req_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!req_ready) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = poke;
        if (poke) begin
            req_a = 4'($urandom); req_b = 4'($urandom); req_cmd = 4'($urandom);
            req_chain = 1'($urandom);
        end
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, b);
        check("alu_cmd", alu_cmd, cmd);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            check("busy_req_ready", req_ready, 0);
            check("busy_alu_a", alu_a, ea);
            rsp_ready = poke ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        rsp_ready = 1'b0;
        check("latency", lat, SETTLE + 1);
        check("rsp_result", rsp_result, er);
        check("rsp_error", rsp_error, ee);
        check("rsp_cmd", rsp_cmd, cmd);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, er);
            check("hold_error", rsp_error, ee);
            check("hold_req_ready", req_ready, 0);
            check("hold_alu_b", alu_b, b);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("taken_valid", rsp_valid, 0);
        check("taken_req_ready", req_ready, 1);
        check("keep_alu_a", alu_a, ea);
        last_res = er;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_alu"}, {alu_a, alu_b, alu_cmd}, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp"}, {rsp_result, rsp_error, rsp_cmd}, 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_chain = 1'b0;
        req_a = 4'd0; req_b = 4'd0; req_cmd = 4'd0; junk = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        do_op(6, 1, 1, 1'b0, 0, 1'b0);
        do_op(6, 1, 2, 1'b0, 0, 1'b0);
        do_op(2, 3, 2, 1'b0, 0, 1'b0);
        do_op(7, 1, 1, 1'b0, 0, 1'b0);
        do_op(4, 4, 5, 1'b0, 0, 1'b0);
        do_op(9, 3, 0, 1'b0, 0, 1'b0);
        do_op(8, 1, 2, 1'b0, 5, 1'b1);

        // Abort during DRIVE
        @(negedge clk);
        req_a = 4'd3; req_b = 4'd3; req_cmd = 4'd1; req_chain = 1'b0; req_valid = 1'b1;
        while (!req_ready) @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            check("abort_no_rsp", rsp_valid, 0);
        end
        last_res = 0;
        do_op(5, 2, 1, 1'b0, 1, 1'b0);

`ifdef BREADBOARD_DRIVER_CHAIN_EN
        do_op(3, 4, 1, 1'b0, 0, 1'b0);
        do_op(0, 2, 2, 1'b1, 0, 1'b0);
        do_op(0, 4, 1, 1'b1, 0, 1'b0);
        check("chain_err_seen", last_res, 9);
`endif

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int cmd;
            cmd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(3, 15))
                                               : int'($urandom_range(0, 2));
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), cmd,
                  1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
